// File: rtl/sub_div_ctrl.sv
// -----------------------------------------------------------------------------
// sub_div_ctrl
//
// Sequencing controller for unsigned WIDTH/WIDTH restoring division. It uses
// one external ripple subtractor, with one trial subtraction per clock, over
// WIDTH iterations. The ALU uses it for DIV/REM.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   start       request; sampled only in IDLE or DONE
//   dividend    numerator, captured on accept
//   divisor     denominator, captured on accept
//   busy        high while iterating
//   done        one-cycle pulse; quotient/remainder/div_by_zero valid
//   div_by_zero divisor of the last accepted op was zero
//   quotient    result, held until the next accept
//   remainder   result, held until the next accept
//   sub_a       subtractor minuend   (0 outside RUN)
//   sub_b       subtractor subtrahend (0 outside RUN)
//   sub_cin     subtractor borrow-in (always 0)
//   sub_diff    subtractor difference (combinational from sub_a/sub_b)
//   sub_borrow  subtractor borrow-out; 1 means sub_a < sub_b
// -----------------------------------------------------------------------------
module sub_div_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic [WIDTH-1:0] sub_a,
    output logic [WIDTH-1:0] sub_b,
    output logic             sub_cin,
    input  logic [WIDTH-1:0] sub_diff,
    input  logic             sub_borrow
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_r, state_s;
    logic [WIDTH-1:0] d_r, d_s;       // dividend shift register / quotient bits
    logic [WIDTH-1:0] v_r, v_s;       // captured divisor
    logic [WIDTH-1:0] r_r, r_s;       // partial remainder
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [WIDTH-1:0] quot_r, quot_s;
    logic [WIDTH-1:0] rem_r, rem_s;
    logic             dbz_r, dbz_s;
    logic             busy_r, done_r;
    logic [WIDTH-1:0] trial_a_s;
    logic             q_bit_s;

    // Subtractor drive: shifted partial remainder against the divisor, RUN only.
    always_comb begin
        trial_a_s = {r_r[WIDTH-2:0], d_r[WIDTH-1]};
        q_bit_s   = ~sub_borrow;
        if (state_r == ST_RUN) begin
            sub_a = trial_a_s;
            sub_b = v_r;
        end else begin
            sub_a = {WIDTH{1'b0}};
            sub_b = {WIDTH{1'b0}};
        end
        sub_cin = 1'b0;
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_s = state_r;
        d_s     = d_r;
        v_s     = v_r;
        r_s     = r_r;
        cnt_s   = cnt_r;
        quot_s  = quot_r;
        rem_s   = rem_r;
        dbz_s   = dbz_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    d_s   = dividend;
                    v_s   = divisor;
                    r_s   = {WIDTH{1'b0}};
                    cnt_s = {CNT_W{1'b0}};
                    if (divisor == {WIDTH{1'b0}}) begin
                        state_s = ST_DONE;
                        quot_s  = {WIDTH{1'b1}};
                        rem_s   = dividend;
                        dbz_s   = 1'b1;
                    end else begin
                        state_s = ST_RUN;
                        dbz_s   = 1'b0;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Restore on borrow: keep the shifted value instead of the difference.
                if (sub_borrow) begin
                    r_s = trial_a_s;
                end else begin
                    r_s = sub_diff;
                end
                d_s   = {d_r[WIDTH-2:0], q_bit_s};
                cnt_s = cnt_r + CNT_ONE;
                if (cnt_r == LAST_CNT) begin
                    state_s = ST_DONE;
                    quot_s  = d_s;
                    rem_s   = r_s;
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            d_r     <= {WIDTH{1'b0}};
            v_r     <= {WIDTH{1'b0}};
            r_r     <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            quot_r  <= {WIDTH{1'b0}};
            rem_r   <= {WIDTH{1'b0}};
            dbz_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            d_r     <= d_s;
            v_r     <= v_s;
            r_r     <= r_s;
            cnt_r   <= cnt_s;
            quot_r  <= quot_s;
            rem_r   <= rem_s;
            dbz_r   <= dbz_s;
            busy_r  <= (state_s == ST_RUN);
            done_r  <= (state_s == ST_DONE);
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign div_by_zero = dbz_r;
    assign quotient    = quot_r;
    assign remainder   = rem_r;

endmodule

// File: tb/tb_sub_div_ctrl.sv
module tb_sub_div_ctrl;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic [WIDTH-1:0] sub_a;
    logic [WIDTH-1:0] sub_b;
    logic             sub_cin;
    logic [WIDTH-1:0] sub_diff;
    logic             sub_borrow;

    int checks   = 0;
    int failures = 0;
    int inv_viol = 0;
    int cin_viol = 0;
    int done_seen = 0;

    sub_div_ctrl #(.WIDTH(WIDTH), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .start(start),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .quotient(quotient), .remainder(remainder),
        .sub_a(sub_a), .sub_b(sub_b), .sub_cin(sub_cin),
        .sub_diff(sub_diff), .sub_borrow(sub_borrow)
    );

    // External ripple subtractor model.
    assign {sub_borrow, sub_diff} = {1'b0, sub_a} - {1'b0, sub_b} - {32'd0, sub_cin};

    always #5 clk = ~clk;

    // Invariants: R stays below V after each iteration, R MSB clear, cin always 0.
    always @(posedge clk) begin
        if (sub_cin !== 1'b0) cin_viol <= cin_viol + 1;
        if (busy === 1'b1) begin
            if (dut.r_r[WIDTH-1] !== 1'b0) inv_viol <= inv_viol + 1;
            if ((sub_borrow ? sub_a : sub_diff) >= sub_b) inv_viol <= inv_viol + 1;
        end
        if (done === 1'b1) done_seen <= done_seen + 1;
    end

    task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive a request at the current negedge; returns at the negedge after accept.
    task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        start = 1'b1; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait for done, counting busy cycles; bounded.
    task automatic wait_done(output int cycles);
        int guard = 0;
        cycles = 0;
        while (done !== 1'b1 && guard < 100) begin
            if (busy === 1'b1) cycles++;
            @(negedge clk);
            guard++;
        end
        chk("done_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic check_result(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int cycles);
        logic [WIDTH-1:0] eq, er;
        if (b == 32'd0) begin eq = 32'hFFFF_FFFF; er = a; end
        else begin eq = a / b; er = a % b; end
        chk({tag, "_q"}, quotient, eq);
        chk({tag, "_r"}, remainder, er);
        chk({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, (b == 32'd0)});
        chk({tag, "_lat"}, 32'(cycles), (b == 32'd0) ? 32'd0 : 32'd32);
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int cyc;
        @(negedge clk);
        launch(a, b);
        wait_done(cyc);
        check_result(tag, a, b, cyc);
    endtask

    initial begin
        int cyc;
        int seen0;
        logic [WIDTH-1:0] ra, rb;
        reset = 1'b1; start = 1'b0; dividend = 32'd0; divisor = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        chk("rst_q", quotient, 32'd0);
        chk("rst_r", remainder, 32'd0);
        chk("rst_suba", sub_a, 32'd0);
        chk("rst_subb", sub_b, 32'd0);
        chk("rst_cin", {31'd0, sub_cin}, 32'd0);
        reset = 1'b0;

        // Directed cases.
        @(negedge clk);
        launch(32'd100, 32'd7);
        chk("first_busy", {31'd0, busy}, 32'd1);
        wait_done(cyc);
        check_result("d100_7", 32'd100, 32'd7, cyc);
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);

        run_op("max_div1", 32'hFFFF_FFFF, 32'd1);
        run_op("msb_maxdiv", 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("max_8001", 32'hFFFF_FFFF, 32'h8000_0001);

        // Divide by zero: done right after accept, busy never high.
        @(negedge clk);
        launch(32'd55, 32'd0);
        chk("dz_done", {31'd0, done}, 32'd1);
        chk("dz_busy", {31'd0, busy}, 32'd0);
        check_result("dz", 32'd55, 32'd0, 0);
        @(negedge clk);
        chk("dz_done_drop", {31'd0, done}, 32'd0);

        // Start during RUN ignored; back-to-back start in the done cycle accepted.
        @(negedge clk);
        launch(32'd100, 32'd7);
        repeat (9) @(negedge clk);
        start = 1'b1; dividend = 32'd9; divisor = 32'd3;
        @(negedge clk);
        start = 1'b0; dividend = 32'd1234; divisor = 32'd5;
        wait_done(cyc);
        check_result("ignored_start", 32'd100, 32'd7, cyc + 10);
        launch(32'd9, 32'd3);
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        wait_done(cyc);
        check_result("b2b", 32'd9, 32'd3, cyc);

        // Reset mid-RUN: immediate abort, no done pulse.
        @(negedge clk);
        launch(32'd100, 32'd7);
        repeat (15) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_suba", sub_a, 32'd0);
        chk("arst_subb", sub_b, 32'd0);
        chk("arst_q", quotient, 32'd0);
        chk("arst_r", remainder, 32'd0);
        seen0 = done_seen;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("arst_no_done", 32'(done_seen), 32'(seen0));
        run_op("after_rst", 32'd20, 32'd20);

        // Randomized operations against the arithmetic model.
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            case (i % 4)
                0: rb = $urandom;
                1: rb = 32'($urandom_range(1, 255));
                2: rb = (i % 8 == 2) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
                default: rb = ra >> $urandom_range(0, 4);
            endcase
            run_op("rand", ra, rb);
        end

        @(negedge clk);
        chk("r_invariant", 32'(inv_viol), 32'd0);
        chk("cin_zero", 32'(cin_viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
